// File: rtl/event_encoder_pkg.sv
// Shared constants and types for the event encoder.
package event_encoder_pkg;

    // Number of request lines (power of two, 2..16) and index width.
    localparam int unsigned N  = 8;
    localparam int unsigned IW = $clog2(N);

    typedef logic [IW-1:0] idx_t;

endpackage

// File: rtl/event_encoder_prio_enc.sv
// Combinational lowest-set-bit priority encoder.
module prio_enc
    import event_encoder_pkg::*;
(
    input  logic [N-1:0] vec,
    output idx_t         idx,
    output logic         found
);

    // Scan from the top down so the lowest set bit wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = idx_t'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/event_encoder.sv
// Event encoder: captures event pulses into a pending vector and issues one
// binary index per valid/ready handshake.
// Build option: define ROUND_ROBIN_EN for rotating priority; otherwise the
// lowest pending index is always issued first.
module event_encoder
    import event_encoder_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic         valid,
    output idx_t         index,
    output logic [N-1:0] pending,
    output logic         drop
);

    logic [N-1:0] p_q, p_d;
    logic         valid_q, valid_d;
    idx_t         index_q, index_d;
    idx_t         last_q, last_d;
    logic         drop_q, drop_d;

    idx_t         sel;
    logic         found;
    logic         issue;
    logic         load;
    logic [N-1:0] sel_mask;

`ifdef ROUND_ROBIN_EN
    idx_t         off;
    idx_t         enc_idx;
    logic [N-1:0] rot;

    // Search starts one past the last issued index; IW-bit wrap gives mod N.
    assign off = last_q + idx_t'(1);

    // Rotate right by off so the first candidate lands at bit 0.
    always_comb begin
        rot = '0;
        for (int j = 0; j < int'(N); j++) begin
            rot[j] = p_q[idx_t'(j + int'(off))];
        end
    end

    prio_enc u_prio_enc (
        .vec   (rot),
        .idx   (enc_idx),
        .found (found)
    );

    assign sel = enc_idx + off;
`else
    prio_enc u_prio_enc (
        .vec   (p_q),
        .idx   (sel),
        .found (found)
    );
`endif

    // Next-state: issue from pending as it stood, then merge new requests.
    always_comb begin
        issue    = !valid_q || ready;
        load     = issue && found;
        sel_mask = '0;
        if (load) begin
            sel_mask[sel] = 1'b1;
        end

        p_d = p_q & ~sel_mask;
        if (en) begin
            p_d = p_d | req;
        end

        // A request on a line being loaded this cycle simply re-arms it.
        drop_d = en && (|(req & p_q & ~sel_mask));

        valid_d = valid_q;
        index_d = index_q;
        last_d  = last_q;
        if (issue) begin
            valid_d = load;
        end
        if (load) begin
            index_d = sel;
            last_d  = sel;
        end
    end

    // State registers; last resets to N-1 so rotation starts at index 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            p_q     <= '0;
            valid_q <= 1'b0;
            index_q <= '0;
            last_q  <= idx_t'(N - 1);
            drop_q  <= 1'b0;
        end else begin
            p_q     <= p_d;
            valid_q <= valid_d;
            index_q <= index_d;
            last_q  <= last_d;
            drop_q  <= drop_d;
        end
    end

    assign valid   = valid_q;
    assign index   = index_q;
    assign pending = p_q;
    assign drop    = drop_q;

endmodule

// File: doc/event_encoder.md
# event_encoder

Sequential request encoder: collects one-hot/multi-hot event pulses on N request lines, holds them as pending, and emits one binary index per handshake on a valid/ready output port, clearing each bit as it is issued. It is the inverse of the library 3-to-8 decoder, turning 8 event lines into 3-bit indices. It sits between event sources (buttons, comparator outputs, timer strobes) and any consumer that accepts one encoded event at a time.

## Interface
- N, default 8: number of request lines; power of two, 2..16.
- IW, default $clog2(N) = 3: index width.
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- en  input  1  request capture enable; when 0, req is ignored.
- req  input  N  event pulses; bit i high for a cycle means one event on line i.
- ready  input  1  consumer accepts index this cycle.
- valid  output  1  index holds a valid event.
- index  output  IW  binary index of the issued event.
- pending  output  N  registered pending vector, not including the bit held in the output register.
- drop  output  1  one-cycle pulse: an event was lost because its line was already pending.

## Operation
- Pending register P[N-1:0]; output register {valid, index}; priority pointer last[IW-1:0].
- Capture: when en=1, each req[i]=1 sets P[i] at the next edge.
- Drop: if en=1, req[i]=1, P[i]=1 and bit i is not being loaded this cycle, the event is lost; drop=1 on the next cycle. Multiple losses in one cycle give a single pulse.
- Load condition: the output register loads when (!valid || ready) and P != 0.
  - The selected bit is chosen from P as it stands before this edge, excluding req arriving this cycle.
  - index gets the selected bit, valid gets 1, and the selected P bit is cleared.
  - last gets the selected index.
- Same-bit collision: if req[i] arrives in the cycle bit i is loaded, P[i] is set again. The clear is overridden and no drop occurs.
- If (!valid || ready) and P == 0, valid goes to 0 on the next edge; index holds its last value.
- While valid=1 and ready=0, index and valid are held stable and the P, last and capture logic continue.
- en=0 does not stall issue; pending events continue to drain.
- Selection order depends on the configuration below.

## Timing
- Reset values: P=0, valid=0, index=0, drop=0, last=N-1, so that with rotation the first priority is index 0.
- Latency: req high in cycle k means P is set from cycle k+1, and valid=1 with that index from cycle k+2 if the output register is free.
- Throughput: one index per cycle while ready=1 and P is non-zero.
- A handshake completes on an edge where valid && ready.
- Reset asserted mid-operation clears everything on that edge, including a held unaccepted index; req in the reset cycle is discarded.
- All outputs are registered; there are no combinational paths from req or ready to any output.

## Configuration
- ROUND_ROBIN_EN defined: rotating priority.
  - The search starts at (last+1) mod N and wraps around.
  - Example: P=8'b1000_0001 with last=0 selects 7; with last=7 it selects 0.
- ROUND_ROBIN_EN undefined: fixed priority, lowest set index first.
  - last is still maintained but not used for selection.

## Structure
- Package event_encoder_pkg: constants N and IW, and typedef idx_t = logic [IW-1:0].
- Sub-module prio_enc, combinational:
  - Input is an N-bit vector; outputs are the lowest-set-bit index and an any flag.
  - Round-robin is implemented as rotate-right by last+1, then prio_enc, then add last+1 mod N.

## Test plan
- Reset then idle: reset=1 for 2 cycles, req=0 → valid=0, index=0, pending=0, drop=0.
- Single event with ready=1, req=8'h10 in cycle 3 → valid=1, index=3'd4 in cycle 5, valid=0 in cycle 6.
- Burst with ROUND_ROBIN_EN defined, ready=1, req=8'hA5 in one cycle:
  - Indices issued in order 0, 2, 5, 7 on consecutive cycles.
  - Without the macro the order is the same; a second req=8'h01 injected while draining preempts 5 and 7 in fixed mode only.
- Backpressure: ready=0 with req=8'h06 → index=1 held with valid=1 for 5 cycles, pending=8'h04; raising ready gives 1 then 2.
- Drop and collision:
  - P[3] pending with ready=0, then req=8'h08 → drop pulses 1 cycle.
  - req[3] in the exact cycle index 3 loads → no drop, and 3 is issued a second time.
- Reset mid-burst: req=8'hFF, reset after 2 issues → all outputs return to reset values next cycle and no further indices are issued.
